// File: rtl/psram_video_pkg.sv
// Shared types and constants for the PSRAM video read/write paths.
// Geometry helpers let each block derive its own constants from its parameters.
package psram_video_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROOM,
    CMD,
    DATA,
    FRAME_END
  } fetch_state_t;

  // Defaults for the 640x480, 16-beat burst configuration
  localparam int BPL      = 640 / 2;
  localparam int BPF      = BPL * 480;
  localparam int ADDR_INC = 16 * 4;

  // One beat carries two 24-bit pixels in 32-bit slots
  localparam int PIX_BITS = 24;
  localparam int PIX0_LSB = 0;
  localparam int PIX1_LSB = 32;

  function automatic int calc_bpl(input int h_pixels);
    return h_pixels / 2;
  endfunction

  function automatic int calc_bpf(input int h_pixels, input int v_lines);
    return (h_pixels / 2) * v_lines;
  endfunction

  function automatic int calc_addr_inc(input int burst_beats);
    return burst_beats * 4;
  endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// Beat-in-line and line position tracker for one video frame.
// line_last/frame_last describe the beat currently being stepped.
module frame_pos_counter #(
  parameter int BPL   = 320,
  parameter int LINES = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic step,
  output logic line_last,
  output logic frame_last
);

  localparam int BEAT_W = $clog2(BPL + 1);
  localparam int LINE_W = $clog2(LINES + 1);

  logic [BEAT_W-1:0] beat_cnt;
  logic [LINE_W-1:0] line_cnt;

  assign line_last  = (beat_cnt == BEAT_W'(BPL - 1));
  assign frame_last = line_last && (line_cnt == LINE_W'(LINES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      line_cnt <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      line_cnt <= '0;
    end else if (step) begin
      if (line_last) begin
        beat_cnt <= '0;
        line_cnt <= frame_last ? '0 : line_cnt + LINE_W'(1);
      end else begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/psram_frame_fetch.sv
// Frame-buffer read scheduler: issues PSRAM burst reads when the pixel FIFO has
// room for a whole burst and tags returned beats with tuser/tlast.
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | stopped, waiting for enable
// WAIT_ROOM | waiting until the FIFO can absorb one full burst
// CMD       | read command presented, waiting for cmd_ready
// DATA      | collecting the beats of the outstanding burst
// FRAME_END | one-cycle frame wrap-up, enable decides restart
module psram_frame_fetch
  import psram_video_pkg::*;
#(
  parameter int DQ_WIDTH      = 16,
  parameter int ADDR_WIDTH    = 21,
  parameter int H_PIXELS      = 640,
  parameter int V_LINES       = 480,
  parameter int BURST_BEATS   = 16,
  parameter int FIFO_WR_DEPTH = 1024,
  parameter int FIFO_MARGIN   = 32
) (
  input  logic                    psram_clock,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [ADDR_WIDTH-1:0]   frame_base,
  input  logic [9:0]              fifo_wnum,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    rd_valid,
  input  logic [4*DQ_WIDTH-1:0]   rd_data,
  output logic                    in_ese_axis_tvalid,
  output logic                    in_ese_axis_tuser,
  output logic                    in_ese_axis_tlast,
  output logic [4*DQ_WIDTH-1:0]   in_ese_axis_tdata,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    err_stray
);

  localparam int LINE_BEATS  = calc_bpl(H_PIXELS);
  localparam int BURST_WORDS = calc_addr_inc(BURST_BEATS);
  localparam int BC_W        = $clog2(BURST_BEATS + 1);

  fetch_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [BC_W-1:0]       burst_cnt;
  logic                  first_r;
  logic                  room_ok;
  logic                  start_frame;
  logic                  beat_in;
  logic                  line_last;
  logic                  frame_last;

  // 11-bit sum so a nearly full FIFO cannot wrap into a false "room" result
  assign room_ok = ({1'b0, fifo_wnum} + 11'(BURST_BEATS)) <= 11'(FIFO_WR_DEPTH - FIFO_MARGIN);

  assign beat_in     = (state == DATA) && rd_valid;
  assign start_frame = enable && ((state == IDLE) || (state == FRAME_END));
  assign cmd_addr    = addr_r;
  assign busy        = (state != IDLE);

  frame_pos_counter #(
    .BPL   (LINE_BEATS),
    .LINES (V_LINES)
  ) u_pos (
    .clk        (psram_clock),
    .rst_n      (rst_n),
    .clear      (start_frame),
    .step       (beat_in),
    .line_last  (line_last),
    .frame_last (frame_last)
  );

  always_comb begin
    state_nxt = state;
    cmd_valid = 1'b0;
    case (state)
      IDLE:      if (enable) state_nxt = WAIT_ROOM;
      WAIT_ROOM: if (room_ok) state_nxt = CMD;
      CMD: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_nxt = DATA;
      end
      DATA: begin
        if (rd_valid && (burst_cnt == BC_W'(1)))
          state_nxt = frame_last ? FRAME_END : WAIT_ROOM;
      end
      FRAME_END: state_nxt = enable ? WAIT_ROOM : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge psram_clock) begin
    if (!rst_n) begin
      state              <= IDLE;
      addr_r             <= '0;
      burst_cnt          <= '0;
      first_r            <= 1'b0;
      in_ese_axis_tvalid <= 1'b0;
      in_ese_axis_tuser  <= 1'b0;
      in_ese_axis_tlast  <= 1'b0;
      in_ese_axis_tdata  <= '0;
      frame_done         <= 1'b0;
      err_stray          <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == FRAME_END);
      err_stray  <= err_stray | (rd_valid && (state != DATA));

      if (start_frame) begin
        addr_r  <= frame_base;
        first_r <= 1'b1;
      end else if (cmd_valid && cmd_ready) begin
        addr_r    <= addr_r + ADDR_WIDTH'(BURST_WORDS);
        burst_cnt <= BC_W'(BURST_BEATS);
      end else if (beat_in) begin
        burst_cnt <= burst_cnt - BC_W'(1);
        first_r   <= 1'b0;
      end

      in_ese_axis_tvalid <= beat_in;
      in_ese_axis_tuser  <= beat_in && first_r;
      in_ese_axis_tlast  <= beat_in && line_last;
      if (beat_in) in_ese_axis_tdata <= rd_data;
    end
  end

endmodule
